demux_lanes_rx: RTL

Single-clock receive-side lane distributor for the byte-interleaved stream produced by the 4:1 lane mux tree. It replaces the two demux stages and their external selectors with an internal lane pointer and an explicit alignment input. It reassembles four byte lanes with per-lane valid flags and presents each completed group as a registered, held output word. It sits between the serial byte link and the four-lane consumers.

---
 rtl/lanes_pkg.sv | 11 +
 rtl/demux_lane_ptr.sv | 27 ++
 rtl/demux_lanes_rx.sv | 90 +++++++++
 3 files changed

// File: rtl/lanes_pkg.sv
// Shared lane constants for the byte-lane mux/demux pair.
package lanes_pkg;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned LANES              = 4;
  localparam int unsigned LANE_IDX_W         = 2;

  localparam logic [LANE_IDX_W-1:0] LANE0 = LANE_IDX_W'(0);
  localparam logic [LANE_IDX_W-1:0] LANE1 = LANE_IDX_W'(1);
  localparam logic [LANE_IDX_W-1:0] LANE2 = LANE_IDX_W'(2);
  localparam logic [LANE_IDX_W-1:0] LANE3 = LANE_IDX_W'(3);
endpackage

// File: rtl/demux_lane_ptr.sv
// Wrapping lane pointer; align forces the current slot to lane 0.
module demux_lane_ptr
  import lanes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  align,
  output logic [LANE_IDX_W-1:0] lane_c,
  output logic                  misalign_c
);

  logic [LANE_IDX_W-1:0] ptr;

  always_comb begin
    lane_c     = align ? LANE0 : ptr;
    misalign_c = align && (ptr != LANE0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= LANE0;
    end else begin
      ptr <= lane_c + LANE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/demux_lanes_rx.sv
// Receive-side lane distributor: buffers lanes 0-2 and emits a held group on lane 3.
module demux_lanes_rx
  import lanes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  align,
  output logic [DATA_WIDTH-1:0] dataOut0,
  output logic [DATA_WIDTH-1:0] dataOut1,
  output logic [DATA_WIDTH-1:0] dataOut2,
  output logic [DATA_WIDTH-1:0] dataOut3,
  output logic                  validOut0,
  output logic                  validOut1,
  output logic                  validOut2,
  output logic                  validOut3,
  output logic                  groupStrobe,
  output logic                  syncErr
);

  logic [LANE_IDX_W-1:0] lane_c;
  logic                  misalign_c;
  logic [DATA_WIDTH-1:0] hold0, hold1, hold2;
  logic [2:0]            hold_valid;

  demux_lane_ptr u_ptr (
    .clk        (clk),
    .reset      (reset),
    .align      (align),
    .lane_c     (lane_c),
    .misalign_c (misalign_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold0       <= '0;
      hold1       <= '0;
      hold2       <= '0;
      hold_valid  <= '0;
      dataOut0    <= '0;
      dataOut1    <= '0;
      dataOut2    <= '0;
      dataOut3    <= '0;
      validOut0   <= 1'b0;
      validOut1   <= 1'b0;
      validOut2   <= 1'b0;
      validOut3   <= 1'b0;
      groupStrobe <= 1'b0;
      syncErr     <= 1'b0;
    end else begin
      groupStrobe <= 1'b0;
      syncErr     <= syncErr | misalign_c;
      // A realignment drops the partial group; lane 0 is rewritten below.
      if (misalign_c) begin
        hold_valid[1] <= 1'b0;
        hold_valid[2] <= 1'b0;
      end
      case (lane_c)
        LANE0: begin
          hold0         <= dataIn;
          hold_valid[0] <= validIn;
        end
        LANE1: begin
          hold1         <= dataIn;
          hold_valid[1] <= validIn;
        end
        LANE2: begin
          hold2         <= dataIn;
          hold_valid[2] <= validIn;
        end
        LANE3: begin
          dataOut0    <= hold0;
          dataOut1    <= hold1;
          dataOut2    <= hold2;
          dataOut3    <= dataIn;
          validOut0   <= hold_valid[0];
          validOut1   <= hold_valid[1];
          validOut2   <= hold_valid[2];
          validOut3   <= validIn;
          groupStrobe <= 1'b1;
          hold_valid  <= '0;
        end
      endcase
    end
  end

endmodule
